// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: stall/flush, misaligned/out-of-range access suppression and a saturating fault counter.
// Define EXMEM_STORE_FWD_EN to forward WB write data into the store-data output.
module ex_mem_reg #(
    parameter int DEPTH  = 32,
    parameter int FCNT_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_ex,
    input  logic [31:0]       ALUresult_ex,
    input  logic [31:0]       ReadData2_ex,
    input  logic [4:0]        Rt_ex,
    input  logic [4:0]        WriteReg_ex,
    input  logic              MemWrite_ex,
    input  logic              MemRead_ex,
    input  logic              RegWrite_ex,
    input  logic              MemtoReg_ex,
    input  logic              RegWrite_wb,
    input  logic [4:0]        WriteReg_wb,
    input  logic [31:0]       WriteData_wb,
    output logic              valid_mem,
    output logic [31:0]       ALUresult_mem,
    output logic [31:0]       ReadData2_mem,
    output logic [4:0]        WriteReg_mem,
    output logic              MemWrite_mem,
    output logic              MemRead_mem,
    output logic              RegWrite_mem,
    output logic              MemtoReg_mem,
    output logic              addr_fault_mem,
    output logic [FCNT_W-1:0] fault_count
);

    // 33-bit limit so a DEPTH filling the whole 32-bit space cannot wrap.
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

    logic              valid_q, valid_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       rd2_q, rd2_d;
    logic [4:0]        wr_q, wr_d;
    logic              mw_q, mw_d;
    logic              mr_q, mr_d;
    logic              rw_q, rw_d;
    logic              mtr_q, mtr_d;
    logic              fault_q, fault_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
`ifdef EXMEM_STORE_FWD_EN
    logic [4:0]        rt_q, rt_d;
`endif

    logic mem_access;
    logic addr_fault;

    assign mem_access = valid_ex && (MemRead_ex || MemWrite_ex);
    assign addr_fault = mem_access &&
                        ((ALUresult_ex[1:0] != 2'b00) || ({1'b0, ALUresult_ex} >= ADDR_LIMIT));

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block infers a latch.
        valid_d = valid_q;
        alu_d   = alu_q;
        rd2_d   = rd2_q;
        wr_d    = wr_q;
        mw_d    = mw_q;
        mr_d    = mr_q;
        rw_d    = rw_q;
        mtr_d   = mtr_q;
        fault_d = fault_q;
        fcnt_d  = fcnt_q;
`ifdef EXMEM_STORE_FWD_EN
        rt_d    = rt_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
            alu_d   = '0;
            rd2_d   = '0;
            wr_d    = '0;
            mw_d    = 1'b0;
            mr_d    = 1'b0;
            rw_d    = 1'b0;
            mtr_d   = 1'b0;
            fault_d = 1'b0;
`ifdef EXMEM_STORE_FWD_EN
            rt_d    = '0;
`endif
        end else if (!stall) begin
            valid_d = valid_ex;
            alu_d   = ALUresult_ex;
            rd2_d   = ReadData2_ex;
            wr_d    = WriteReg_ex;
            mw_d    = valid_ex && MemWrite_ex && !addr_fault;
            mr_d    = valid_ex && MemRead_ex  && !addr_fault;
            rw_d    = valid_ex && RegWrite_ex && !addr_fault;
            mtr_d   = valid_ex && MemtoReg_ex;
            fault_d = addr_fault;
`ifdef EXMEM_STORE_FWD_EN
            rt_d    = Rt_ex;
`endif
            if (addr_fault && (fcnt_q != '1)) begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (!reset_n) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            rd2_q   <= '0;
            wr_q    <= '0;
            mw_q    <= 1'b0;
            mr_q    <= 1'b0;
            rw_q    <= 1'b0;
            mtr_q   <= 1'b0;
            fault_q <= 1'b0;
            fcnt_q  <= '0;
`ifdef EXMEM_STORE_FWD_EN
            rt_q    <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            rd2_q   <= rd2_d;
            wr_q    <= wr_d;
            mw_q    <= mw_d;
            mr_q    <= mr_d;
            rw_q    <= rw_d;
            mtr_q   <= mtr_d;
            fault_q <= fault_d;
            fcnt_q  <= fcnt_d;
`ifdef EXMEM_STORE_FWD_EN
            rt_q    <= rt_d;
`endif
        end
    end

`ifdef EXMEM_STORE_FWD_EN
    // WB inputs are held for the full cycle, so the forwarded value is stable for the falling-edge write.
    logic fwd_hit;
    assign fwd_hit       = mw_q && RegWrite_wb && (WriteReg_wb != 5'd0) && (WriteReg_wb == rt_q);
    assign ReadData2_mem = fwd_hit ? WriteData_wb : rd2_q;
`else
    logic unused_fwd;
    assign unused_fwd    = ^{Rt_ex, RegWrite_wb, WriteReg_wb, WriteData_wb};
    assign ReadData2_mem = rd2_q;
`endif

    assign valid_mem      = valid_q;
    assign ALUresult_mem  = alu_q;
    assign WriteReg_mem   = wr_q;
    assign MemWrite_mem   = mw_q;
    assign MemRead_mem    = mr_q;
    assign RegWrite_mem   = rw_q;
    assign MemtoReg_mem   = mtr_q;
    assign addr_fault_mem = fault_q;
    assign fault_count    = fcnt_q;

endmodule
